// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state encoding and default frame geometry for the sobel controller, core and benches.
package sobel_pkg;
  localparam int PIX_W = 8;
  localparam int WIDTH = 512;
  localparam int HEIGHT = 512;
  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;
endpackage

// File: rtl/sobel_rc_counter.sv
// sobel_rc_counter: raster row/col tracker reporting the position of the last accepted pixel.
module sobel_rc_counter #(
  parameter int W = sobel_pkg::WIDTH,
  parameter int H = sobel_pkg::HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  output logic [$clog2(H)-1:0] row,
  output logic [$clog2(W)-1:0] col,
  output logic                 last
);
  import sobel_pkg::*;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  logic [RW-1:0] row_q, row_d, nrow_q, nrow_d;
  logic [CW-1:0] col_q, col_d, ncol_q, ncol_d;
  logic wrap_c;
  // nrow/ncol hold the position the next accepted pixel will occupy
  assign wrap_c = ncol_q == CW'(W - 1);
  assign last = wrap_c && nrow_q == RW'(H - 1);
  always_comb begin
    ncol_d = clr ? '0 : en ? (wrap_c ? '0 : ncol_q + CW'(1)) : ncol_q;
    nrow_d = clr ? '0 : (en && wrap_c) ? (last ? '0 : nrow_q + RW'(1)) : nrow_q;
    col_d = clr ? '0 : en ? ncol_q : col_q;
    row_d = clr ? '0 : en ? nrow_q : row_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      nrow_q <= '0;
      ncol_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      nrow_q <= nrow_d;
      ncol_q <= ncol_d;
    end
  end
  assign row = row_q;
  assign col = col_q;
endmodule

// File: rtl/sobel_frame_ctrl.sv
// sobel_frame_ctrl: streams one raster frame into sobel_core, flushes its line buffers and counts results.
// Define SOBEL_CTRL_THRESH_EN to binarise dst_pixel against a threshold sampled at start.
module sobel_frame_ctrl #(
  parameter int WIDTH = sobel_pkg::WIDTH,
  parameter int HEIGHT = sobel_pkg::HEIGHT,
  parameter int FLUSH_PIXELS = WIDTH + 1,
  parameter int EXP_OUT = WIDTH * HEIGHT,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef SOBEL_CTRL_THRESH_EN
  input  logic [sobel_pkg::PIX_W-1:0]   threshold,
`endif
  input  logic                          start,
  input  logic                          src_valid,
  input  logic [sobel_pkg::PIX_W-1:0]   src_pixel,
  output logic                          src_ready,
  output logic [sobel_pkg::PIX_W-1:0]   core_pixel_in,
  output logic                          core_valid_in,
  input  logic [sobel_pkg::PIX_W-1:0]   core_pixel_out,
  input  logic                          core_valid_out,
  output logic [sobel_pkg::PIX_W-1:0]   dst_pixel,
  output logic                          dst_valid,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          err_timeout,
  output logic [$clog2(HEIGHT)-1:0]     row,
  output logic [$clog2(WIDTH)-1:0]      col
);
  import sobel_pkg::*;
  localparam int OW = $clog2(EXP_OUT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int FW = FLUSH_PIXELS > 1 ? $clog2(FLUSH_PIXELS) : 1;
  state_t state_q, state_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] wd_q, wd_d;
  logic [FW-1:0] fl_q, fl_d;
  logic [PIX_W-1:0] cpi_q, cpi_d, dst_pix_q, dst_pix_d, res;
  logic cvi_q, cvi_d, dst_val_q, dst_val_d, err_q, err_d;
  logic go, accept, last, watch, flush_end, drained, abort;
  assign go = start && state_q == IDLE;
  assign accept = src_valid && state_q == STREAM;
  assign watch = state_q == FLUSH || state_q == DRAIN;
  assign flush_end = int'(fl_q) == FLUSH_PIXELS - 1;
  sobel_rc_counter #(.W(WIDTH), .H(HEIGHT)) u_rc (
    .clk (clk),
    .rst (rst),
    .clr (go),
    .en  (accept),
    .row (row),
    .col (col),
    .last(last)
  );
`ifdef SOBEL_CTRL_THRESH_EN
  logic [PIX_W-1:0] thr_q, thr_d;
  assign thr_d = go ? threshold : thr_q;
  assign res = core_pixel_out >= thr_q ? '1 : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) thr_q <= '0;
    else thr_q <= thr_d;
  end
`else
  assign res = core_pixel_out;
`endif
  always_comb begin
    cvi_d = accept || state_q == FLUSH;
    cpi_d = accept ? src_pixel : state_q == FLUSH ? '0 : cpi_q;
    dst_val_d = core_valid_out && state_q != IDLE;
    dst_pix_d = dst_val_d ? res : dst_pix_q;
    out_cnt_d = go ? '0 : (dst_val_d && out_cnt_q != OW'(EXP_OUT)) ? out_cnt_q + OW'(1) : out_cnt_q;
    wd_d = (core_valid_out || !watch) ? '0 : wd_q + TW'(1);
    fl_d = state_q == FLUSH ? fl_q + FW'(1) : '0;
    drained = state_q == DRAIN && out_cnt_d == OW'(EXP_OUT);
    // a result beat in the expiry cycle clears the watchdog, so it never aborts here
    abort = watch && wd_d == TW'(TIMEOUT) && !drained;
    err_d = !go && (err_q || abort);
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = go ? STREAM : IDLE;
      STREAM:  state_d = (accept && last) ? (FLUSH_PIXELS == 0 ? DRAIN : FLUSH) : STREAM;
      FLUSH:   state_d = abort ? IDLE : flush_end ? DRAIN : FLUSH;
      DRAIN:   state_d = drained ? DONE : abort ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      out_cnt_q <= '0;
      wd_q <= '0;
      fl_q <= '0;
      cpi_q <= '0;
      cvi_q <= 1'b0;
      dst_pix_q <= '0;
      dst_val_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_cnt_q <= out_cnt_d;
      wd_q <= wd_d;
      fl_q <= fl_d;
      cpi_q <= cpi_d;
      cvi_q <= cvi_d;
      dst_pix_q <= dst_pix_d;
      dst_val_q <= dst_val_d;
      err_q <= err_d;
    end
  end
  assign src_ready = state_q == STREAM;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign core_pixel_in = cpi_q;
  assign core_valid_in = cvi_q;
  assign dst_pixel = dst_pix_q;
  assign dst_valid = dst_val_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// tb_sobel_frame_ctrl: frame-level checks of sobel_frame_ctrl against a stub core echoing its input 3 cycles later.
module tb_sobel_frame_ctrl;
  localparam int W = 4, H = 3, FP = 2, EXP = 14, TO = 8;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, src_valid = 1'b0;
  logic [7:0] src_pixel = '0;
  logic src_ready, core_valid_in, core_valid_out, dst_valid, busy, frame_done, err_timeout;
  logic [7:0] core_pixel_in, core_pixel_out, dst_pixel;
  logic [1:0] row, col;
`ifdef SOBEL_CTRL_THRESH_EN
  logic [7:0] threshold = '0;
  int thr_samp;
`endif
  always #5 clk = ~clk;

  sobel_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .FLUSH_PIXELS(FP), .EXP_OUT(EXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
`ifdef SOBEL_CTRL_THRESH_EN
    .threshold(threshold),
`endif
    .start(start), .src_valid(src_valid), .src_pixel(src_pixel), .src_ready(src_ready),
    .core_pixel_in(core_pixel_in), .core_valid_in(core_valid_in),
    .core_pixel_out(core_pixel_out), .core_valid_out(core_valid_out),
    .dst_pixel(dst_pixel), .dst_valid(dst_valid), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .row(row), .col(col)
  );

  // stub core: 3-cycle echo that goes silent after echo_limit beats of the current frame
  logic [2:0] v_sh = '0;
  logic [7:0] p_sh0 = '0, p_sh1 = '0, p_sh2 = '0;
  int echoed = 0, echo_limit = 99;
  assign core_valid_out = v_sh[2] && (echoed < echo_limit);
  assign core_pixel_out = p_sh2;
  always @(posedge clk) begin
    v_sh <= {v_sh[1:0], core_valid_in};
    p_sh0 <= core_pixel_in;
    p_sh1 <= p_sh0;
    p_sh2 <= p_sh1;
    echoed <= start ? 0 : echoed + (core_valid_out ? 1 : 0);
  end

  typedef struct {
    int mode;  // 0 valid always, 1 valid toggling, 2 random valid and pixels
    int lim;
    int spur;
    int thr;
    int exp_done;
    int exp_err;
    int exp_dst;
    int exp_run;
    int exp_gap;
  } vec_t;
  vec_t tbl[5];

  int checks = 0, failures = 0;
  int r_done, r_err, r_run, r_gap;
  byte unsigned exp_pix[$];
  byte unsigned r_dst[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mdst(input int p);
`ifdef SOBEL_CTRL_THRESH_EN
    return p >= thr_samp ? 255 : 0;
`else
    return p;
`endif
  endfunction

  task automatic run_frame(input vec_t v);
    int acc, cyc, run, last_cvo, bad, e;
    bit fin;
    byte unsigned cin[$];
    acc = 0; cyc = 0; run = 0; last_cvo = -100; fin = 0;
    exp_pix.delete(); r_dst.delete();
    r_done = 0; r_err = 0; r_run = 0; r_gap = -1;
    echo_limit = v.lim;
`ifdef SOBEL_CTRL_THRESH_EN
    threshold = 8'(v.thr);
    thr_samp = v.thr;
`endif
    @(posedge clk); #1 start = 1'b1; src_valid = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    while (!fin && cyc < 300) begin
      src_valid = v.mode == 0 ? 1'b1 : v.mode == 1 ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      src_pixel = v.mode == 2 ? 8'($urandom) : 8'(acc + 1);
      start = v.spur != 0 && cyc == 3;
`ifdef SOBEL_CTRL_THRESH_EN
      threshold = 8'($urandom);
`endif
      @(negedge clk);
      if (cyc == 0) chk("err_cleared_by_start", err_timeout, 0);
      chk("src_ready", src_ready, acc < W * H);
      if (acc > 0) begin
        chk("row", row, (acc - 1) / W);
        chk("col", col, (acc - 1) % W);
      end
      if (src_valid && acc < W * H) begin
        exp_pix.push_back(src_pixel);
        acc++;
      end
      if (core_valid_in) begin
        cin.push_back(core_pixel_in);
        run++;
        if (run > r_run) r_run = run;
      end else run = 0;
      if (dst_valid) r_dst.push_back(dst_pixel);
      if (core_valid_out) last_cvo = cyc;
      if (frame_done) r_done++;
      chk("busy", busy, !err_timeout);
      if (err_timeout) begin
        r_err = 1;
        r_gap = cyc - last_cvo - 1;
        fin = 1;
      end
      if (frame_done) fin = 1;
      cyc++;
      @(posedge clk); #1;
    end
    chk("frame_ended_in_budget", fin, 1);
    src_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_end", busy, 0);
    chk("frame_done_single_pulse", frame_done, 0);
    chk("core_in_len", cin.size(), acc + FP);
    bad = 0;
    foreach (cin[i]) if (int'(cin[i]) != (i < exp_pix.size() ? int'(exp_pix[i]) : 0)) bad++;
    chk("core_in_data_errors", bad, 0);
    bad = 0;
    foreach (r_dst[i]) begin
      e = i < exp_pix.size() ? int'(exp_pix[i]) : 0;
      if (int'(r_dst[i]) != mdst(e)) bad++;
    end
    chk("dst_data_errors", bad, 0);
  endtask

  initial begin
    tbl[0] = '{mode: 0, lim: 99, spur: 0, thr: 6,   exp_done: 1, exp_err: 0, exp_dst: 14, exp_run: 14, exp_gap: -1};
    tbl[1] = '{mode: 1, lim: 99, spur: 0, thr: 6,   exp_done: 1, exp_err: 0, exp_dst: 14, exp_run: 3,  exp_gap: -1};
    tbl[2] = '{mode: 2, lim: 99, spur: 1, thr: 100, exp_done: 1, exp_err: 0, exp_dst: 14, exp_run: -1, exp_gap: -1};
    tbl[3] = '{mode: 0, lim: 10, spur: 0, thr: 6,   exp_done: 0, exp_err: 1, exp_dst: 10, exp_run: 14, exp_gap: TO};
    tbl[4] = '{mode: 2, lim: 5,  spur: 0, thr: 200, exp_done: 0, exp_err: 1, exp_dst: 5,  exp_run: -1, exp_gap: -1};
    #2 rst = 1'b1;
    #6;
    chk("reset_outputs", {busy, src_ready, row, col, core_valid_in, core_pixel_in, dst_valid, dst_pixel,
                          frame_done, err_timeout}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      run_frame(tbl[t]);
      chk("frame_done_count", r_done, tbl[t].exp_done);
      chk("err_timeout", r_err, tbl[t].exp_err);
      chk("dst_count", r_dst.size(), tbl[t].exp_dst);
      chk("last_row", row, H - 1);
      chk("last_col", col, W - 1);
      if (tbl[t].exp_run > 0) chk("core_valid_in_run", r_run, tbl[t].exp_run);
      if (tbl[t].exp_gap >= 0) chk("watchdog_idle_cycles", r_gap, tbl[t].exp_gap);
      repeat (6) @(negedge clk);
    end
    // reset asserted mid-stream after five pixels
    echo_limit = 99;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_pixel = 8'(k + 1);
      src_valid = 1'b1;
      @(posedge clk); #1;
    end
    src_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_row", row, 1);
    chk("pre_reset_col", col, 0);
    chk("pre_reset_core_pixel", core_pixel_in, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_outputs", {busy, src_ready, row, col, core_valid_in, core_pixel_in, dst_valid, dst_pixel,
                                frame_done, err_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_frame(tbl[0]);
    chk("post_reset_done", r_done, 1);
    chk("post_reset_dst_count", r_dst.size(), EXP);
    chk("post_reset_err", r_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
